// File: rtl/can_error_detection_pkg.sv
// Shared constants and types for the CAN error detection block.
package can_pkg;

    // Counter increments applied per detected error
    localparam int unsigned TEC_TX_INC    = 8;
    localparam int unsigned REC_RX_INC    = 1;

    // Fault confinement thresholds
    localparam int unsigned PASSIVE_LIMIT = 128;
    localparam int unsigned BUS_OFF_LIMIT = 256;
    localparam int unsigned REC_MAX       = 255;

    typedef enum logic [1:0] {
        ERR_ACTIVE,
        ERR_PASSIVE,
        BUS_OFF
    } fault_state_e;

endpackage

// File: rtl/can_fault_confinement.sv
// Transmit/receive error counters and fault confinement state decode.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ERR_ACTIVE  | tec < 128 and rec < 128, node sends active error flags
//   ERR_PASSIVE | tec >= 128 or rec >= 128, node sends passive flags
//   BUS_OFF     | tec reached 256, counters frozen until reset
module can_fault_confinement
    import can_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_err,
    input  logic       rx_err,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic       error_active,
    output logic       error_passive,
    output logic       bus_off
);

    logic [9:0]   tec_sum;
    logic [8:0]   tec_next;
    logic [7:0]   rec_next;
    logic         frozen;
    fault_state_e state;

    // Saturating next values for both counters
    always_comb begin
        tec_sum  = 10'(tec) + 10'(TEC_TX_INC);
        tec_next = tec_sum[8:0];
        if (tec_sum >= 10'(BUS_OFF_LIMIT)) begin
            tec_next = 9'(BUS_OFF_LIMIT);
        end
        rec_next = rec + 8'(REC_RX_INC);
        if (rec == 8'(REC_MAX)) begin
            rec_next = rec;
        end
        frozen = (tec >= 9'(BUS_OFF_LIMIT));
    end

    // Counter registers; bus-off freezes both until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tec <= '0;
            rec <= '0;
        end else if (!frozen) begin
            if (tx_err) begin
                tec <= tec_next;
            end else if (rx_err) begin
                rec <= rec_next;
            end
        end
    end

    // Fault state decoded straight from the registered counters
    always_comb begin
        state = ERR_ACTIVE;
        if (tec >= 9'(BUS_OFF_LIMIT)) begin
            state = BUS_OFF;
        end else if ((tec >= 9'(PASSIVE_LIMIT)) || (rec >= 8'(PASSIVE_LIMIT))) begin
            state = ERR_PASSIVE;
        end
        error_active  = (state == ERR_ACTIVE);
        error_passive = (state == ERR_PASSIVE);
        bus_off       = (state == BUS_OFF);
    end

endmodule

// File: rtl/can_error_detection.sv
// CAN protocol error detection: bit, stuff, CRC, ACK and form errors,
// feeding the fault confinement counters.
module can_error_detection
    import can_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       tx_bit,
    input  logic       tx_active,
    input  logic       sample_point,
    input  logic       bit_de_stuffing_ff,
    input  logic       remove_stuff_bit,
    input  logic       rx_bit_curr,
    input  logic       rx_bit_prev,
    input  logic       in_arbitration,
    input  logic       in_ack_slot,
    input  logic       sending_error_flag_passive,
    input  logic       in_crc_delimiter,
    input  logic       in_ack_delimiter,
    input  logic       in_eof,
    input  logic       crc_check_done,
    input  logic       crc_rx_valid,
    input  logic       crc_rx_match,
    output logic       bit_error,
    output logic       stuff_error,
    output logic       crc_error,
    output logic       form_error,
    output logic       ack_error,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic       error_active,
    output logic       error_passive,
    output logic       bus_off
);

    logic bit_error_d;
    logic stuff_error_d;
    logic crc_error_d;
    logic ack_error_d;
    logic form_error_d;
    logic any_err;
    logic tx_err;
    logic rx_err;

    // Combinational detection terms; CRC result is strobed independently
    // of the sample point
    always_comb begin
        bit_error_d   = sample_point & tx_active & (rx_bit != tx_bit) &
                        ~in_arbitration & ~in_ack_slot & ~sending_error_flag_passive;
        stuff_error_d = sample_point & bit_de_stuffing_ff & remove_stuff_bit &
                        (rx_bit_curr == rx_bit_prev);
        crc_error_d   = crc_check_done & crc_rx_valid & ~crc_rx_match;
        ack_error_d   = sample_point & tx_active & in_ack_slot & rx_bit;
        form_error_d  = sample_point & (in_crc_delimiter | in_ack_delimiter | in_eof) & ~rx_bit;
        any_err       = bit_error_d | stuff_error_d | crc_error_d | ack_error_d | form_error_d;
        tx_err        = any_err & tx_active;
        rx_err        = any_err & ~tx_active;
    end

    // One-cycle registered error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_error   <= 1'b0;
            stuff_error <= 1'b0;
            crc_error   <= 1'b0;
            form_error  <= 1'b0;
            ack_error   <= 1'b0;
        end else begin
            bit_error   <= bit_error_d;
            stuff_error <= stuff_error_d;
            crc_error   <= crc_error_d;
            form_error  <= form_error_d;
            ack_error   <= ack_error_d;
        end
    end

    can_fault_confinement u_fault_confinement (
        .clk           (clk),
        .rst           (rst),
        .tx_err        (tx_err),
        .rx_err        (rx_err),
        .tec           (tec),
        .rec           (rec),
        .error_active  (error_active),
        .error_passive (error_passive),
        .bus_off       (bus_off)
    );

endmodule

// File: tb/tb_can_error_detection.sv
// Self-checking bench for can_error_detection: vector table, threshold
// sequences and randomized stimulus against a counter-level reference model.
module tb_can_error_detection;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_bit, tx_bit, tx_active, sample_point;
    logic       bit_de_stuffing_ff, remove_stuff_bit, rx_bit_curr, rx_bit_prev;
    logic       in_arbitration, in_ack_slot, sending_error_flag_passive;
    logic       in_crc_delimiter, in_ack_delimiter, in_eof;
    logic       crc_check_done, crc_rx_valid, crc_rx_match;
    logic       bit_error, stuff_error, crc_error, form_error, ack_error;
    logic [8:0] tec;
    logic [7:0] rec;
    logic       error_active, error_passive, bus_off;

    always #5 clk = ~clk;

    can_error_detection dut (
        .clk                        (clk),
        .rst                        (rst),
        .rx_bit                     (rx_bit),
        .tx_bit                     (tx_bit),
        .tx_active                  (tx_active),
        .sample_point               (sample_point),
        .bit_de_stuffing_ff         (bit_de_stuffing_ff),
        .remove_stuff_bit           (remove_stuff_bit),
        .rx_bit_curr                (rx_bit_curr),
        .rx_bit_prev                (rx_bit_prev),
        .in_arbitration             (in_arbitration),
        .in_ack_slot                (in_ack_slot),
        .sending_error_flag_passive (sending_error_flag_passive),
        .in_crc_delimiter           (in_crc_delimiter),
        .in_ack_delimiter           (in_ack_delimiter),
        .in_eof                     (in_eof),
        .crc_check_done             (crc_check_done),
        .crc_rx_valid               (crc_rx_valid),
        .crc_rx_match               (crc_rx_match),
        .bit_error                  (bit_error),
        .stuff_error                (stuff_error),
        .crc_error                  (crc_error),
        .form_error                 (form_error),
        .ack_error                  (ack_error),
        .tec                        (tec),
        .rec                        (rec),
        .error_active               (error_active),
        .error_passive              (error_passive),
        .bus_off                    (bus_off)
    );

    typedef struct packed {
        logic rx_bit, tx_bit, tx_active, sp;
        logic dsff, rsb, cur, prev;
        logic arb, ack, efp;
        logic crcd, ackd, eof;
        logic done, valid, match;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [4:0] exp_flags;   // {bit, stuff, crc, form, ack}
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   m_tec  = 0;
    int   m_rec  = 0;
    logic [4:0] m_flags = '0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Error flags as the protocol rules define them
    function automatic logic [4:0] rule_errors(input stim_t s);
        logic b, st, c, f, a;
        b  = s.sp && s.tx_active && (s.rx_bit != s.tx_bit) && !s.arb && !s.ack && !s.efp;
        st = s.sp && s.dsff && s.rsb && (s.cur == s.prev);
        c  = s.done && s.valid && !s.match;
        f  = s.sp && (s.crcd || s.ackd || s.eof) && !s.rx_bit;
        a  = s.sp && s.tx_active && s.ack && s.rx_bit;
        return {b, st, c, f, a};
    endfunction

    function automatic int imin(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model_step(input stim_t s, input logic r);
        if (r) begin
            m_tec = 0; m_rec = 0; m_flags = '0;
        end else begin
            m_flags = rule_errors(s);
            if (m_tec < 256 && m_flags != 0) begin
                if (s.tx_active) m_tec = imin(m_tec + 8, 256);
                else             m_rec = imin(m_rec + 1, 255);
            end
        end
    endtask

    task automatic drive(input stim_t s, input logic r);
        rst = r;
        rx_bit = s.rx_bit; tx_bit = s.tx_bit; tx_active = s.tx_active; sample_point = s.sp;
        bit_de_stuffing_ff = s.dsff; remove_stuff_bit = s.rsb;
        rx_bit_curr = s.cur; rx_bit_prev = s.prev;
        in_arbitration = s.arb; in_ack_slot = s.ack; sending_error_flag_passive = s.efp;
        in_crc_delimiter = s.crcd; in_ack_delimiter = s.ackd; in_eof = s.eof;
        crc_check_done = s.done; crc_rx_valid = s.valid; crc_rx_match = s.match;
    endtask

    // One clock: drive, clock, advance model, sample 1 time unit after the edge
    task automatic step(input stim_t s, input logic r);
        drive(s, r);
        @(posedge clk);
        #1;
        model_step(s, r);
    endtask

    task automatic check_all(input string tag);
        int exp_state;
        exp_state = (m_tec >= 256) ? 1 : ((m_tec >= 128 || m_rec >= 128) ? 2 : 4);
        check({tag, " flags"}, int'({bit_error, stuff_error, crc_error, form_error, ack_error}), int'(m_flags));
        check({tag, " tec"}, int'(tec), m_tec);
        check({tag, " rec"}, int'(rec), m_rec);
        check({tag, " state"}, int'({error_active, error_passive, bus_off}), exp_state);
    endtask

    function automatic void add(input stim_t s, input logic [4:0] f, input string n);
        vec_t v;
        v.s = s; v.exp_flags = f; v.name = n;
        vecs.push_back(v);
    endfunction

    stim_t idle;
    stim_t s;

    initial begin
        idle = '0;
        idle.rx_bit = 1'b1; idle.tx_bit = 1'b1; idle.match = 1'b1;

        s = idle; s.tx_active = 1; s.rx_bit = 0; s.sp = 1;
        add(s, 5'b10000, "bit_err_tx");
        s.arb = 1;
        add(s, 5'b00000, "bit_in_arb");
        s = idle; s.tx_active = 1; s.rx_bit = 0; s.sp = 1; s.efp = 1;
        add(s, 5'b00000, "bit_passive_flag");
        s = idle; s.tx_active = 1; s.rx_bit = 0; s.sp = 0;
        add(s, 5'b00000, "bit_no_sp");
        s = idle; s.sp = 1; s.dsff = 1; s.rsb = 1; s.cur = 1; s.prev = 1;
        add(s, 5'b01000, "stuff_err_rx");
        s.prev = 0;
        add(s, 5'b00000, "stuff_ok");
        s = idle; s.done = 1; s.valid = 1; s.match = 0;
        add(s, 5'b00100, "crc_err_no_sp");
        s.match = 1;
        add(s, 5'b00000, "crc_match");
        s = idle; s.tx_active = 1; s.ack = 1; s.rx_bit = 1; s.sp = 1;
        add(s, 5'b00001, "ack_err");
        s.rx_bit = 0; s.tx_bit = 1;
        add(s, 5'b00000, "ack_ok_mismatch_masked");
        s = idle; s.ackd = 1; s.rx_bit = 0; s.sp = 1;
        add(s, 5'b00010, "form_ackd_1");
        add(s, 5'b00010, "form_ackd_2");
        s = idle; s.crcd = 1; s.rx_bit = 1; s.sp = 1;
        add(s, 5'b00000, "form_ok");
        s = idle; s.tx_active = 1; s.tx_bit = 1; s.rx_bit = 0; s.sp = 1; s.eof = 1;
        add(s, 5'b10010, "bit_and_form_tx");

        // Reset state
        step(idle, 1'b1);
        check_all("reset");
        check("reset error_active", int'(error_active), 1);

        // Vector table
        foreach (vecs[i]) begin
            step(vecs[i].s, 1'b0);
            check({vecs[i].name, " tbl_flags"},
                  int'({bit_error, stuff_error, crc_error, form_error, ack_error}),
                  int'(vecs[i].exp_flags));
            check_all(vecs[i].name);
        end
        step(idle, 1'b0);
        check_all("pulse_clears");

        // Tx thresholds: 16 bit errors to passive, 32 to bus-off
        step(idle, 1'b1);
        s = idle; s.tx_active = 1; s.rx_bit = 0; s.sp = 1;
        for (int i = 0; i < 16; i++) step(s, 1'b0);
        check("tec_16", int'(tec), 128);
        check("passive_16", int'(error_passive), 1);
        check_all("after_16_tx");
        for (int i = 0; i < 15; i++) step(s, 1'b0);
        check("tec_31", int'(tec), 248);
        check("not_busoff_31", int'(bus_off), 0);
        step(s, 1'b0);
        check("tec_32", int'(tec), 256);
        check("busoff_32", int'({error_active, error_passive, bus_off}), 1);
        for (int i = 0; i < 4; i++) step(s, 1'b0);
        check("tec_frozen", int'(tec), 256);
        s = idle; s.sp = 1; s.ackd = 1; s.rx_bit = 0;
        for (int i = 0; i < 4; i++) step(s, 1'b0);
        check("rec_frozen", int'(rec), 0);
        check_all("busoff_sticky");
        // Reset while an error is being detected
        step(s, 1'b1);
        check_all("reset_mid_frame");
        check("reset_form_flag", int'(form_error), 0);

        // Rx saturation
        for (int i = 0; i < 300; i++) step(s, 1'b0);
        check("rec_sat", int'(rec), 255);
        check("rx_passive", int'(error_passive), 1);
        check_all("after_300_rx");
        step(idle, 1'b1);
        check_all("final_reset");

        // Randomized stimulus against the model
        for (int n = 0; n < 3000; n++) begin
            stim_t rs;
            logic  r;
            rs = stim_t'($urandom);
            rs.sp = ($urandom_range(0, 3) != 0);
            rs.done = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 499) == 0);
            step(rs, r);
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_error_detection.md
Name: can_error_detection

Overview:
- Detects the five CAN protocol error types: bit, stuff, CRC, ACK and form.
- Maintains the Transmit Error Counter (TEC) and Receive Error Counter (REC), and derives the node fault-confinement state: error-active, error-passive or bus-off.
- Sits beside the CAN bit-stream processor and consumes its frame-field qualifiers, destuffer status and CRC checker result.
- Error flags and the fault state feed the error-frame generator and the host status registers.

Parameters:
- none. Thresholds and increments are package constants; see Decomposition.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_bit  in  1  sampled bus level (1 = recessive)
- tx_bit  in  1  level this node is driving
- tx_active  in  1  node is transmitter of the current frame
- sample_point  in  1  one-cycle strobe at the bit sample point
- bit_de_stuffing_ff  in  1  destuffer active (inside a stuffed field)
- remove_stuff_bit  in  1  current bit is an expected stuff bit
- rx_bit_curr  in  1  current destuffer bit
- rx_bit_prev  in  1  previous destuffer bit
- in_arbitration  in  1  inside the arbitration field
- in_ack_slot  in  1  ACK slot bit
- sending_error_flag_passive  in  1  node is sending a passive error flag
- in_crc_delimiter  in  1  CRC delimiter bit
- in_ack_delimiter  in  1  ACK delimiter bit
- in_eof  in  1  end-of-frame field
- crc_check_done  in  1  CRC comparison complete (strobe)
- crc_rx_valid  in  1  received CRC captured
- crc_rx_match  in  1  received CRC equals computed CRC
- bit_error  out  1  registered error pulse
- stuff_error  out  1  registered error pulse
- crc_error  out  1  registered error pulse
- form_error  out  1  registered error pulse
- ack_error  out  1  registered error pulse
- tec  out  9  transmit error counter
- rec  out  8  receive error counter
- error_active  out  1  fault state flag
- error_passive  out  1  fault state flag
- bus_off  out  1  fault state flag

Behaviour:
- Reset (rst=1 at a clk edge): all five error flags = 0, tec = 0, rec = 0. Fault state: error_active = 1, error_passive = 0, bus_off = 0.
- Detection terms are combinational; each error flag is registered, so it asserts for exactly one cycle after the qualifying edge.
  - bit_error_d = sample_point & tx_active & (rx_bit != tx_bit) & ~in_arbitration & ~in_ack_slot & ~sending_error_flag_passive.
  - stuff_error_d = sample_point & bit_de_stuffing_ff & remove_stuff_bit & (rx_bit_curr == rx_bit_prev).
  - crc_error_d = crc_check_done & crc_rx_valid & ~crc_rx_match. This term is not gated by sample_point.
  - ack_error_d = sample_point & tx_active & in_ack_slot & rx_bit.
  - form_error_d = sample_point & (in_crc_delimiter | in_ack_delimiter | in_eof) & ~rx_bit.
- Counter update occurs on the same edge that registers the flags.
  - Tx-side error (any *_d with tx_active = 1): tec += 8.
  - Rx-side error (any *_d with tx_active = 0): rec += 1.
  - At most one increment per cycle, regardless of how many errors coincide.
- Saturation:
  - rec saturates at 255.
  - tec saturates at 256. Once tec >= 256, no further tec/rec changes occur until reset; bus-off is sticky.
- There is no decrement path. Success accounting is outside this block.
- Fault state is combinational from the registered counters, and exactly one flag is high at any time:
  - bus_off = (tec >= 256).
  - error_passive = ~bus_off & (tec >= 128 | rec >= 128).
  - error_active = ~bus_off & ~error_passive.
- Reset asserted mid-frame clears everything on that edge and overrides all detections.

Decomposition:
- Package can_pkg holds:
  - TEC_TX_INC = 8, REC_RX_INC = 1
  - PASSIVE_LIMIT = 128, BUS_OFF_LIMIT = 256, REC_MAX = 255
  - a typedef enum for the fault state {ERR_ACTIVE, ERR_PASSIVE, BUS_OFF}.
- One sub-module, can_fault_confinement, owns the counters and state decode. It takes tx_err/rx_err pulses and outputs tec, rec and the three state flags.

Test Plan:
1. Bit error: tx_active=1, tx_bit=1, rx_bit=0, sample_point=1 for one cycle. Required: bit_error=1 next cycle, tec=8, rec=0, error_active=1. Repeat with in_arbitration=1: no error, tec unchanged.
2. Stuff error: tx_active=0, bit_de_stuffing_ff=1, remove_stuff_bit=1, rx_bit_curr=rx_bit_prev=1, sample_point=1. Required: stuff_error=1, rec +1, tec unchanged.
3. CRC error: crc_check_done=1, crc_rx_valid=1, crc_rx_match=0, sample_point=0. Required: crc_error=1, rec +1. With crc_rx_match=1: no error.
4. ACK error: tx_active=1, in_ack_slot=1, rx_bit=1, sample_point=1. Required: ack_error=1, tec +8, bit_error=0.
5. Form error: tx_active=0, in_ack_delimiter=1, rx_bit=0, sample_point=1 held 2 cycles. Required: form_error high 2 cycles, rec +2.
6. Thresholds: 16 tx bit errors give tec=128, error_passive=1. 32 give tec=256, bus_off=1, error_active=0, counters frozen. 300 rx errors give rec=255. rst=1 returns tec=0, rec=0, error_active=1.
